// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers, fixed-priority vector selection and a
// three-state IME machine with delayed EI arming.
module interrupt_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  irq_in,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        instr_done,
  input  logic        int_ack,
  output logic        int_req,
  output logic        wake,
  output logic [2:0]  int_pc_out
);

  typedef enum logic [1:0] {IME_OFF, IME_ARMED, IME_ON} ime_t;

  ime_t       state_q;
  ime_t       state_d;
  logic [4:0] if_q;
  logic [4:0] if_d;
  logic [7:0] ie_q;
  logic [2:0] int_pc_q;
  logic [4:0] pending;
  logic [4:0] ack_mask;
  logic       ack_valid;
  logic       sel_if;
  logic       sel_ie;

  // Lowest bit index wins: vblank has the highest priority.
  function automatic logic [2:0] prio_idx(input logic [4:0] p);
    logic [2:0] idx;
    casez (p)
      5'b????1: idx = 3'd0;
      5'b???10: idx = 3'd1;
      5'b??100: idx = 3'd2;
      5'b?1000: idx = 3'd3;
      5'b10000: idx = 3'd4;
      default:  idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [4:0] idx_mask(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

  assign sel_if    = (bus_addr == 16'hFF0F);
  assign sel_ie    = (bus_addr == 16'hFFFF);
  assign bus_hit   = sel_if | sel_ie;
  assign bus_rdata = sel_if ? {3'b111, if_q} : (sel_ie ? ie_q : 8'hFF);

  assign pending    = ie_q[4:0] & if_q;
  assign wake       = |pending;
  assign ack_valid  = int_ack & int_req;
  assign ack_mask   = ack_valid ? idx_mask(prio_idx(pending)) : 5'b00000;
  assign int_pc_out = int_pc_q;

  // Write first, then ack clear, then new requests, so a coincident pulse survives.
  always_comb begin
    if_d = (bus_we & sel_if) ? bus_wdata[4:0] : if_q;
    if_d = if_d & ~ack_mask;
    if_d = if_d | irq_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_q     <= 5'b00000;
      ie_q     <= 8'h00;
      int_pc_q <= 3'd0;
    end else begin
      if_q <= if_d;
      if (bus_we & sel_ie)
        ie_q <= bus_wdata;
      if (ack_valid)
        int_pc_q <= prio_idx(pending);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IME_OFF;
    else
      state_q <= state_d;
  end

  // ARMED is only entered at the ei edge, so any instr_done seen while ARMED is
  // from a later instruction; a repeated ei holds the arming back.
  always_comb begin
    state_d = state_q;
    if (int_ack)
      state_d = IME_OFF;
    else if (di)
      state_d = IME_OFF;
    else if (reti)
      state_d = IME_ON;
    else if (ei && state_q == IME_OFF)
      state_d = IME_ARMED;
    else if (!ei && instr_done && state_q == IME_ARMED)
      state_d = IME_ON;
  end

  always_comb begin
    int_req = 1'b0;
    if (state_q == IME_ON)
      int_req = |pending;
  end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Ports SHALL be, in order:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- irq_in  in  5  one-cycle request pulses: [0] vblank, [1] lcd stat, [2] timer, [3] serial, [4] joypad
- bus_addr  in  16  CPU memory address
- bus_wdata  in  8  CPU write data
- bus_we  in  1  CPU write strobe, one cycle
- bus_rdata  out  8  read data for FF0F/FFFF, combinational
- bus_hit  out  1  1 when bus_addr is 16'hFF0F or 16'hFFFF
- ei  in  1  EI instruction executed, pulse
- di  in  1  DI instruction executed, pulse
- reti  in  1  RETI executed, pulse
- instr_done  in  1  instruction-boundary pulse from sequencer
- int_ack  in  1  sequencer begins interrupt dispatch, pulse
- int_req  out  1  interrupt must be dispatched at next boundary
- wake  out  1  exit HALT; independent of IME
- int_pc_out  out  3  latched vector index, feeds PC unit int_pc_in (target 16'h0040 + 8*index)
REQ-002 Clock is one domain; reset is synchronous and active-high.

Function
REQ-003 IF SHALL be a 5-bit register at FF0F, and IE an 8-bit register at FFFF.
REQ-004 Reads SHALL return {3'b111, IF} at FF0F and IE at FFFF; all other addresses return 8'hFF with bus_hit=0.
REQ-005 IF next value SHALL be computed in this order: base = (bus_we & addr FF0F) ? bus_wdata[4:0] : IF; then base & ~ack_mask; then | irq_in.
- A request arriving in the same cycle as an ack or write therefore stays pending.
REQ-006 An IE write SHALL store all 8 bits; only IE[4:0] take part in any logic.
REQ-007 pending = IE[4:0] & IF. Priority SHALL be lowest bit index first; bit 0 is highest.
REQ-008 wake SHALL be |pending, combinational, regardless of IME state.
REQ-009 The IME state machine SHALL have three states: OFF, ARMED, ON.
REQ-010 Transitions SHALL be evaluated in priority order, first match wins:
- int_ack -> OFF
- di -> OFF
- reti -> ON
- ei while OFF -> ARMED
- ARMED with instr_done in a cycle after the ei cycle -> ON
- otherwise hold
REQ-011 ei while ARMED or ON SHALL leave the state unchanged.
REQ-012 instr_done in the same cycle as ei SHALL NOT complete the arming.
REQ-013 int_req SHALL be (state==ON) & |pending, combinational.
REQ-014 On int_ack with int_req=1, the block SHALL register the priority-encoded index into int_pc_out and set ack_mask to the one-hot bit of that index; the IF bit clears at the same posedge.
REQ-015 int_pc_out SHALL hold its value until the next valid ack.
- Requests raised after the ack do not alter it.
REQ-016 int_ack with int_req=0 SHALL force the state to OFF, leave IF and int_pc_out unchanged, and use ack_mask=0.
REQ-017 Dispatch latency: int_ack at posedge N -> int_pc_out valid and IF bit cleared after posedge N, i.e. during cycle N+1.

Reset
REQ-018 While reset=1 at a posedge, the block SHALL set IF=0, IE=0, state=OFF and int_pc_out=0.
- Outputs after that edge: int_req=0, wake=0.
REQ-019 Reset SHALL override all inputs in the same cycle, including irq_in, bus_we, ei and int_ack; a request pulse coincident with reset is lost.
REQ-020 Reset mid-ARMED SHALL return the state machine to OFF; there is no residual arming.

Verification
REQ-021 IE=8'h1F, IME ON, irq_in=5'b10100 in one pulse -> int_req=1; int_ack -> int_pc_out=3'd2, IF=5'b10000, int_req=0.
REQ-022 IME OFF, IE=8'h01, irq_in[0] pulse -> wake=1, int_req=0; ei, then instr_done two cycles later -> int_req=1 in the cycle after that instr_done.
REQ-023 ei and instr_done in the same cycle, then no instr_done -> state stays ARMED and int_req stays 0; di -> OFF.
REQ-024 Write FF0F=8'h00 in the same cycle as irq_in=5'b00100 -> IF=5'b00100; read FF0F -> 8'hE4; read FFFF after writing 8'hE5 -> 8'hE5.
REQ-025 int_ack with IF bit 0 pending and irq_in[0] pulsing in the same cycle -> int_pc_out=0, IF[0] stays 1, state OFF; reti -> int_req=1.
REQ-026 Reset asserted while ARMED with IF=5'h1F -> next cycle IF=0, IE=0, int_pc_out=0, int_req=0, wake=0.
